// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: pairs each issued PC with the ROM word returned a cycle later,
// buffers the pair, and hands one registered instruction per cycle to ID.
module inst_fetch_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [ADDR_W-1:0] i_pc,
  input  logic              i_ce,
  input  logic [DATA_W-1:0] i_rom_inst,
  input  logic [5:0]        i_stall,
  input  logic              i_flush,
  output logic [ADDR_W-1:0] o_id_pc,
  output logic [DATA_W-1:0] o_id_inst,
  output logic              o_id_valid,
  output logic              o_stallreq_if,
  output logic              o_overflow_err
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] r_mem_pc   [DEPTH];
  logic [DATA_W-1:0] r_mem_inst [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_inflight;
  logic [ADDR_W-1:0] r_pc_d1;
  logic [ADDR_W-1:0] r_id_pc;
  logic [DATA_W-1:0] r_id_inst;
  logic              r_id_valid;
  logic              r_overflow_err;

  logic              w_issue;
  logic              w_push_req;
  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic [CNT_W:0]    w_occupancy;
  logic              w_unused;

  assign w_issue    = i_ce & ~i_stall[0];
  assign w_push_req = r_inflight & ~i_flush;
  assign w_full     = (r_count == CNT_W'(DEPTH));
  assign w_empty    = (r_count == '0);
  assign w_push     = w_push_req & ~w_full;
  assign w_pop      = ~i_flush & ~i_stall[1] & ~w_empty;

  // One slot stays reserved for the fetch that may be issued in the same cycle.
  assign w_occupancy   = {1'b0, r_count} + (CNT_W+1)'(r_inflight);
  assign o_stallreq_if = (w_occupancy >= (CNT_W+1)'(DEPTH - 1));

  assign w_unused = ^i_stall[5:2];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_inflight <= 1'b0;
      r_pc_d1    <= '0;
    end else if (i_flush) begin
      r_inflight <= 1'b0;
      r_pc_d1    <= '0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) r_pc_d1 <= i_pc;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem_pc[r_wr_ptr]   <= r_pc_d1;
      r_mem_inst[r_wr_ptr] <= i_rom_inst;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  // Overflow is sticky across flushes; only reset clears it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_overflow_err <= 1'b0;
    end else if (w_push_req && w_full) begin
      r_overflow_err <= 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_id_pc    <= '0;
      r_id_inst  <= '0;
      r_id_valid <= 1'b0;
    end else if (i_flush) begin
      r_id_pc    <= '0;
      r_id_inst  <= '0;
      r_id_valid <= 1'b0;
    end else if (!i_stall[1]) begin
      if (w_empty) begin
        r_id_pc    <= '0;
        r_id_inst  <= '0;
        r_id_valid <= 1'b0;
      end else begin
        r_id_pc    <= r_mem_pc[r_rd_ptr];
        r_id_inst  <= r_mem_inst[r_rd_ptr];
        r_id_valid <= 1'b1;
      end
    end
  end

  assign o_id_pc        = r_id_pc;
  assign o_id_inst      = r_id_inst;
  assign o_id_valid     = r_id_valid;
  assign o_overflow_err = r_overflow_err;

endmodule
